smpl_rate_ctrl: RTL
===================

SMPL_RATE_CTRL -- requirements
Module: smpl_rate_ctrl

Interface
REQ-001 SHALL have parameter NUM_RATES, default 4, number of selectable sample rates (2..16).
REQ-002 SHALL have parameter DEB_CYCLES, default 250000, consecutive stable cycles needed to accept a button level change.
REQ-003 SHALL have parameter WRAP, default 1; 1 = index wraps at the ends, 0 = index saturates.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(NUM_RATES)).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-006 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_up  input  1  raw asynchronous button, active-high, requests a slower rate (index+1).
REQ-008 SHALL have port i_down  input  1  raw asynchronous button, active-high, requests a faster rate (index-1).
REQ-009 SHALL have port i_lock  input  1  capture in progress; rate requests are discarded while high.
REQ-010 SHALL have port o_smpl_sel  output  SEL_W  active rate index, registered.
REQ-011 SHALL have port o_smpl_en  output  1  sample strobe, one clk wide, every 2^o_smpl_sel cycles.
REQ-012 SHALL have port o_change  output  1  one-cycle pulse in the cycle o_smpl_sel takes a new value.
REQ-013 SHALL have port o_LED  output  NUM_RATES  active-low thermometer rate display.

Function
REQ-014 SHALL pass i_up and i_down each through a 2-flop synchroniser before any other use.
REQ-015 SHALL debounce each synchronised button independently: per-input counter increments while the synchronised level differs from the stored stable level, clears when equal; stable level toggles and counter clears when the count reaches DEB_CYCLES-1.
REQ-016 SHALL generate a button event on a stable-level 1->0 transition (release), one cycle wide; latency from raw release to event is DEB_CYCLES+3 cycles.
REQ-017 SHALL discard events that occur while i_lock=1; they are not queued.
REQ-018 SHALL discard both events when up and down events occur in the same cycle.
REQ-019 SHALL compute the requested index: up at NUM_RATES-1 gives 0 if WRAP=1 else holds; down at 0 gives NUM_RATES-1 if WRAP=1 else holds; otherwise +/-1.
REQ-020 SHALL store an accepted request in a pending register with a pending flag; a later event overwrites the pending value, computed from the pending value.
REQ-021 SHALL run a down-counter (width NUM_RATES-1, min 1) reloaded with 2^o_smpl_sel-1; o_smpl_en=1 in each cycle the counter is 0.
REQ-022 SHALL apply a pending request only in a cycle where the counter is 0: o_smpl_sel takes the pending value next cycle, o_change=1 in that cycle, the counter reloads with 2^new-1, pending flag clears.
REQ-023 SHALL not pulse o_change and shall clear pending without update when the pending value equals the current index.
REQ-024 SHALL drive o_LED[i]=0 for i<=o_smpl_sel and 1 otherwise, registered with o_smpl_sel.
REQ-025 SHALL guarantee no o_smpl_en period shorter than the smaller of the old and new rate periods across a switch.

Reset
REQ-026 SHALL, while i_reset=1 at a clk edge, set o_smpl_sel=0, o_LED={NUM_RATES-1{1},0}, o_smpl_en=0, o_change=0, counter=0, pending flag=0, debounce counters=0, stable levels=0, synchronisers=0.
REQ-027 SHALL give o_smpl_en=1 in the first cycle after i_reset deasserts (counter 0, index 0).
REQ-028 SHALL, on reset mid-debounce or with a request pending, discard all such state.

Verification
REQ-029 SHALL bench: NUM_RATES=4, DEB_CYCLES=4, press/release i_up once -> o_smpl_sel 0->1, o_change one pulse, o_LED 1110->1100, o_smpl_en every 2 cycles.
REQ-030 SHALL bench: i_up pulses of 2 cycles (shorter than DEB_CYCLES) -> no event, o_smpl_sel unchanged.
REQ-031 SHALL bench: WRAP=1, index 3, i_up release -> index 0; WRAP=0, index 3, i_up release -> index stays 3, no o_change.
REQ-032 SHALL bench: index 3 (period 8), i_down release mid-period -> update only after the next o_smpl_en, next strobe 4 cycles later.
REQ-033 SHALL bench: i_lock=1 during release -> no change after i_lock drops; simultaneous up/down events -> no change.
REQ-034 SHALL bench: i_reset asserted with request pending at index 2 -> o_smpl_sel=0, o_LED=1110, o_smpl_en=1 first cycle after release, no later o_change.

Source files
------------

// File: rtl/smpl_rate_ctrl.sv
// smpl_rate_ctrl -- push-button controlled sample-rate selector.
//
// Two raw buttons step a rate index up (slower) or down (faster). Each
// button is synchronised and debounced, and it acts on release. An accepted
// request waits in a pending register. It is applied only on a strobe
// boundary, so no sample period is ever cut short by a rate switch.
//
// Ports:
//   clk         system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_up        raw button, request index+1 (slower)
//   i_down      raw button, request index-1 (faster)
//   i_lock      capture in progress; button events are dropped while high
//   o_smpl_sel  registered active rate index
//   o_smpl_en   one-cycle strobe every 2^o_smpl_sel cycles
//   o_change    one-cycle pulse in the first cycle of a new index
//   o_LED       active-low thermometer of the index (bit i lit for i<=sel)

// Per-button synchroniser + debouncer. rel pulses for one cycle when the
// debounced level falls (button released).
module smpl_rate_btn #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rel
);
  localparam int DW = ($clog2(DEB_CYCLES) > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      rel    <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rel  <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        cnt    <= '0;
        stable <= ~stable;
        rel    <= stable;   // only a 1->0 flip is an event
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module smpl_rate_ctrl #(
  parameter int NUM_RATES  = 4,
  parameter int DEB_CYCLES = 250000,
  parameter int WRAP       = 1
) (
  input  logic                             clk,
  input  logic                             i_reset,
  input  logic                             i_up,
  input  logic                             i_down,
  input  logic                             i_lock,
  output logic [((($clog2(NUM_RATES)) > 1) ? $clog2(NUM_RATES) : 1)-1:0] o_smpl_sel,
  output logic                             o_smpl_en,
  output logic                             o_change,
  output logic [NUM_RATES-1:0]             o_LED
);
  localparam int SEL_W = ($clog2(NUM_RATES) > 1) ? $clog2(NUM_RATES) : 1;
  localparam int CNT_W = (NUM_RATES - 1 > 1) ? NUM_RATES - 1 : 1;
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(NUM_RATES - 1);

  // bit 0 = up, bit 1 = down
  logic [1:0] raw, rel;
  assign raw = {i_down, i_up};

  smpl_rate_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn [1:0] (
    .clk   (clk),
    .reset (i_reset),
    .raw   (raw),
    .rel   (rel)
  );

  logic [SEL_W-1:0] sel, pend_val, base, req_val, sel_nxt;
  logic             pend_vld, req_vld, apply, cnt_zero;
  logic [CNT_W-1:0] cnt, reload;
  logic [CNT_W:0]   pow2;
  logic [NUM_RATES-1:0] led_nxt;

  // Back-to-back requests chain from the pending value, not the live index.
  always_comb begin
    base    = pend_vld ? pend_val : sel;
    req_val = base;
    req_vld = 1'b0;
    if (!i_lock && (rel[0] ^ rel[1])) begin
      req_vld = 1'b1;
      if (rel[0])
        req_val = (base == IDX_MAX) ? ((WRAP != 0) ? '0 : base) : base + 1'b1;
      else
        req_val = (base == '0) ? ((WRAP != 0) ? IDX_MAX : base) : base - 1'b1;
    end
  end

  // Switching only when the counter hits zero makes the old period complete
  // before the new one begins.
  assign cnt_zero = (cnt == '0);
  assign apply    = pend_vld && cnt_zero;
  assign sel_nxt  = apply ? pend_val : sel;
  assign pow2     = {{CNT_W{1'b0}}, 1'b1} << sel_nxt;
  assign reload   = CNT_W'(pow2 - 1'b1);

  always_comb begin
    led_nxt = '1;
    for (int i = 0; i < NUM_RATES; i++)
      led_nxt[i] = (i > int'(sel_nxt));
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      sel      <= '0;
      o_LED    <= {{(NUM_RATES-1){1'b1}}, 1'b0};
      o_change <= 1'b0;
      cnt      <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
    end else begin
      o_change <= apply && (pend_val != sel);
      sel      <= sel_nxt;
      o_LED    <= led_nxt;
      cnt      <= cnt_zero ? reload : cnt - 1'b1;
      if (req_vld) begin
        pend_vld <= 1'b1;
        pend_val <= req_val;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

  assign o_smpl_sel = sel;
  assign o_smpl_en  = cnt_zero && !i_reset;
endmodule
